// File: rtl/instr_ctrl_pkg.sv
// Shared definitions for the instruction controller slice.
// Holds the opcode map, FSM state encoding and register-bank addresses
// so the controller, the ALU and the register bank agree on one set of
// values.
//   Types   : instr_t, regAddr_t, opcode_t, state_t
//   Consts  : REG_ACC (accumulator address; reg_a = 00, reg_b = 01)
//   Helpers : isLegalOp()
package instr_ctrl_pkg;

    typedef logic [7:0] instr_t;
    typedef logic [1:0] regAddr_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_MOV = 4'd5,
        OP_MUL = 4'd6
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_READ,
        ST_EXEC,
        ST_WRITE
    } state_t;

    localparam regAddr_t REG_ACC = 2'b10;

    // MUL is the highest defined opcode; everything above it is rejected.
    function automatic logic isLegalOp(input logic [3:0] op);
        return (op <= 4'(OP_MUL));
    endfunction

endpackage

// File: rtl/instr_ctrl_if.sv
// Instruction / register-bank / ALU control bundle of the controller.
//   instr_valid, instr   : instruction offer from the fetch side
//   instr_ready          : controller can accept an instruction
//   opwrite, reg_write   : register-bank write enable and write address
//   src_1, src_2         : register-bank read addresses
//   alu_en, alu_op       : ALU enable and operation
//   done, illegal        : instruction completed / opcode rejected
// master = instruction source and observer, slave = the controller.
interface instr_ctrl_if import instr_ctrl_pkg::*; ();

    logic       instr_valid;
    instr_t     instr;
    logic       instr_ready;
    logic       opwrite;
    regAddr_t   reg_write;
    regAddr_t   src_1;
    regAddr_t   src_2;
    logic       alu_en;
    logic [2:0] alu_op;
    logic       done;
    logic       illegal;

    modport master (
        output instr_valid, instr,
        input  instr_ready, opwrite, reg_write, src_1, src_2,
               alu_en, alu_op, done, illegal
    );

    modport slave (
        input  instr_valid, instr,
        output instr_ready, opwrite, reg_write, src_1, src_2,
               alu_en, alu_op, done, illegal
    );

endinterface

// File: rtl/instr_ctrl_decode.sv
// Combinational opcode decode for the instruction controller.
//   i_opcode : IR[7:4]
//   i_src2   : IR[1:0], doubles as the MOV destination
//   o_legal  : opcode is defined
//   o_isNop  : opcode is NOP
//   o_isMul  : opcode is MUL (multi-cycle execute)
//   o_dest   : register-bank write address for the WRITE phase
//   o_aluOp  : ALU operation code
module instr_decode import instr_ctrl_pkg::*; (
    input  logic [3:0] i_opcode,
    input  regAddr_t   i_src2,
    output logic       o_legal,
    output logic       o_isNop,
    output logic       o_isMul,
    output regAddr_t   o_dest,
    output logic [2:0] o_aluOp
);

    // Arithmetic/logic results always land in the accumulator; MOV
    // copies src_1 through the ALU into the register named by IR[1:0].
    always_comb begin
        o_legal = isLegalOp(i_opcode);
        o_isNop = (i_opcode == 4'(OP_NOP));
        o_isMul = (i_opcode == 4'(OP_MUL));
        o_aluOp = i_opcode[2:0];
        o_dest  = (i_opcode == 4'(OP_MOV)) ? i_src2 : REG_ACC;
    end

endmodule

// File: rtl/instr_ctrl.sv
// Instruction controller: accepts one 8-bit instruction at a time and
// sequences register-bank reads, ALU execution and the result write.
//   MUL_CYCLES : EXEC length for MUL (1..15)
//   CLK        : clock, rising edge
//   RST        : asynchronous active-high reset
//   bus        : instr_ctrl_if.slave (instruction handshake, register-bank
//                and ALU controls, done/illegal status)
// Flow: IDLE -> DECODE -> READ -> EXEC (1 or MUL_CYCLES) -> WRITE -> IDLE,
// with NOP and illegal opcodes returning to IDLE straight from DECODE.
module instr_ctrl import instr_ctrl_pkg::*; #(
    parameter int MUL_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        RST,
    instr_ctrl_if.slave bus
);

    // Counter counts down to zero, so MUL loads one less than its length.
    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    state_t     r_state;
    state_t     w_nextState;
    instr_t     r_ir;
    logic [3:0] r_cnt;

    logic       w_accept;
    logic       w_legal;
    logic       w_isNop;
    logic       w_isMul;
    regAddr_t   w_dest;
    logic [2:0] w_aluOp;

    instr_decode u_decode (
        .i_opcode (r_ir[7:4]),
        .i_src2   (r_ir[1:0]),
        .o_legal  (w_legal),
        .o_isNop  (w_isNop),
        .o_isMul  (w_isMul),
        .o_dest   (w_dest),
        .o_aluOp  (w_aluOp)
    );

    // Offers are only looked at while idle; anything on the bus during
    // a running instruction is ignored.
    assign w_accept = (r_state == ST_IDLE) && bus.instr_valid;

    // State register. Reset is asynchronous so an in-flight write is
    // cut off immediately, not at the next edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Instruction register, captured on the accepting edge and held
    // until the next acceptance.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ir <= '0;
        end else if (w_accept) begin
            r_ir <= bus.instr;
        end
    end

    // EXEC length counter: loaded while in READ so it is valid on the
    // first EXEC cycle, then stepped down until it reaches zero.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (r_state == ST_READ) begin
            r_cnt <= w_isMul ? MUL_LOAD : 4'd0;
        end else if ((r_state == ST_EXEC) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Next-state logic.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_nextState = ST_DECODE;
            end
            ST_DECODE: begin
                if (!w_legal || w_isNop) w_nextState = ST_IDLE;
                else                     w_nextState = ST_READ;
            end
            ST_READ: begin
                w_nextState = ST_EXEC;
            end
            ST_EXEC: begin
                if (r_cnt == 4'd0) w_nextState = ST_WRITE;
            end
            ST_WRITE: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Moore output decode. Read addresses stay up through WRITE so a MOV
    // source is still presented to the ALU while its result is written.
    always_comb begin
        bus.instr_ready = 1'b0;
        bus.opwrite     = 1'b0;
        bus.reg_write   = '0;
        bus.src_1       = '0;
        bus.src_2       = '0;
        bus.alu_en      = 1'b0;
        bus.alu_op      = '0;
        bus.done        = 1'b0;
        bus.illegal     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.instr_ready = 1'b1;
            end
            ST_DECODE: begin
                bus.illegal = !w_legal;
                bus.done    = w_legal && w_isNop;
            end
            ST_READ: begin
                bus.src_1 = r_ir[3:2];
                bus.src_2 = r_ir[1:0];
            end
            ST_EXEC: begin
                bus.src_1  = r_ir[3:2];
                bus.src_2  = r_ir[1:0];
                bus.alu_en = 1'b1;
                bus.alu_op = w_aluOp;
            end
            ST_WRITE: begin
                bus.src_1     = r_ir[3:2];
                bus.src_2     = r_ir[1:0];
                bus.opwrite   = 1'b1;
                bus.reg_write = w_dest;
                bus.done      = 1'b1;
            end
            default: begin
                bus.instr_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_ctrl.sv
// Testbench for instr_ctrl: fixed scenario table, hand-written reset and
// back-to-back sequences, then randomized instructions compared every
// cycle against a cycle-index model of the instruction timeline.
module tb_instr_ctrl;

    localparam int MULC = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    instr_ctrl_if bus ();

    instr_ctrl #(.MUL_CYCLES(MULC)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Observed/expected output snapshot; a same-typed mask selects the
    // fields a given comparison cares about.
    typedef struct packed {
        logic       ready;
        logic       opwrite;
        logic [1:0] regWrite;
        logic [1:0] src1;
        logic [1:0] src2;
        logic       aluEn;
        logic [2:0] aluOp;
        logic       done;
        logic       illegal;
    } outs_t;

    typedef struct {
        logic [7:0] instr;
        int         cycle;
        outs_t      exp;
        outs_t      mask;
        string      name;
    } vec_t;

    vec_t  vecs[$];
    int    checks = 0;
    int    errors = 0;
    outs_t idleExp;
    outs_t allMask;

    function automatic outs_t mk(input logic rdy, input logic ow,
                                 input logic [1:0] rw, input logic [1:0] s1,
                                 input logic [1:0] s2, input logic ae,
                                 input logic [2:0] ao, input logic dn,
                                 input logic il);
        outs_t o;
        o.ready = rdy; o.opwrite = ow; o.regWrite = rw; o.src1 = s1;
        o.src2 = s2; o.aluEn = ae; o.aluOp = ao; o.done = dn; o.illegal = il;
        return o;
    endfunction

    // Number of cycles from the accepting edge to the last busy cycle.
    function automatic int traceLen(input logic [7:0] ins);
        int op;
        op = int'(ins[7:4]);
        if (op == 0 || op > 6) return 1;
        return 3 + ((op == 6) ? MULC : 1);
    endfunction

    // Reference timeline: cycle k after acceptance (k = 1 is the cycle
    // right after the accepting edge).
    function automatic void expOut(input logic [7:0] ins, input int k,
                                   output outs_t e, output outs_t m);
        int op;
        int execLen;
        op      = int'(ins[7:4]);
        execLen = (op == 6) ? MULC : 1;
        e = '0;
        m = '1;
        if (k > traceLen(ins)) begin
            e.ready = 1'b1;
        end else if (k == 1) begin
            e.illegal = (op > 6);
            e.done    = (op == 0);
        end else if (k == 2) begin
            e.src1 = ins[3:2];
            e.src2 = ins[1:0];
            m.regWrite = '0;
            m.aluOp    = '0;
        end else if (k < 3 + execLen) begin
            e.src1  = ins[3:2];
            e.src2  = ins[1:0];
            e.aluEn = 1'b1;
            e.aluOp = ins[6:4];
            m.regWrite = '0;
        end else begin
            e.opwrite  = 1'b1;
            e.done     = 1'b1;
            e.regWrite = (op == 5) ? ins[1:0] : 2'b10;
            m.src1  = '0;
            m.src2  = '0;
            m.aluOp = '0;
        end
    endfunction

    // One clock, then settle past the edge before looking at outputs.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] ins);
        bus.instr_valid = v;
        bus.instr       = ins;
    endtask

    task automatic checkOutput(input string name, input outs_t e, input outs_t m);
        outs_t      a;
        logic [13:0] av;
        logic [13:0] ev;
        logic [13:0] mv;
        a = mk(bus.instr_ready, bus.opwrite, bus.reg_write, bus.src_1,
               bus.src_2, bus.alu_en, bus.alu_op, bus.done, bus.illegal);
        av = a;
        ev = e;
        mv = m;
        checks++;
        if (((av ^ ev) & mv) !== 14'd0) begin
            errors++;
            $display("[TB] FAIL %s: got %b required %b (care %b) [rdy ow rw s1 s2 ae aop dn il]",
                     name, av, ev, mv);
        end
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (bus.instr_ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        if (bus.instr_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL idleTimeout: instr_ready=%b after 40 cycles, required 1",
                     bus.instr_ready);
        end
    endtask

    task automatic addVec(input logic [7:0] ins, input int cyc,
                          input outs_t e, input outs_t m, input string name);
        vec_t v;
        v.instr = ins; v.cycle = cyc; v.exp = e; v.mask = m; v.name = name;
        vecs.push_back(v);
    endtask

    function automatic logic [7:0] randomInstr();
        int unsigned r;
        logic [3:0]  op;
        logic [3:0]  regs;
        r = $urandom_range(0, 9);
        op = (r <= 6) ? 4'(r) : 4'($urandom_range(7, 15));
        regs = 4'($urandom);
        return {op, regs};
    endfunction

    initial begin
        outs_t e;
        outs_t m;
        outs_t srcMask;
        outs_t execMask;
        outs_t writeMask;
        int    len;
        int    gap;
        logic [7:0] ins;

        idleExp   = mk(1, 0, 2'b00, 2'b00, 2'b00, 0, 3'd0, 0, 0);
        allMask   = '1;
        srcMask   = mk(1, 1, 2'b00, 2'b11, 2'b11, 1, 3'd0, 1, 1);
        execMask  = mk(1, 1, 2'b00, 2'b00, 2'b00, 1, 3'd7, 1, 1);
        writeMask = mk(1, 1, 2'b11, 2'b00, 2'b00, 1, 3'd0, 1, 1);

        // Scenario table: instruction, cycle after acceptance, expectation.
        addVec(8'h11, 1, mk(0,0,2'b00,2'b00,2'b00,0,3'd0,0,0), allMask,   "ADD decode");
        addVec(8'h11, 2, mk(0,0,2'b00,2'b00,2'b01,0,3'd0,0,0), srcMask,   "ADD read");
        addVec(8'h11, 3, mk(0,0,2'b00,2'b00,2'b01,1,3'd1,0,0), execMask,  "ADD exec");
        addVec(8'h11, 4, mk(0,1,2'b10,2'b00,2'b00,0,3'd0,1,0), writeMask, "ADD write");
        addVec(8'h11, 5, idleExp,                              allMask,   "ADD idle");
        addVec(8'h60, 2, mk(0,0,2'b00,2'b00,2'b00,0,3'd0,0,0), srcMask,   "MUL read");
        addVec(8'h60, 3, mk(0,0,2'b00,2'b00,2'b00,1,3'd6,0,0), execMask,  "MUL exec first");
        addVec(8'h60, 6, mk(0,0,2'b00,2'b00,2'b00,1,3'd6,0,0), execMask,  "MUL exec last");
        addVec(8'h60, 7, mk(0,1,2'b10,2'b00,2'b00,0,3'd0,1,0), writeMask, "MUL write");
        addVec(8'h60, 8, idleExp,                              allMask,   "MUL idle");
        addVec(8'h59, 2, mk(0,0,2'b00,2'b10,2'b01,0,3'd0,0,0), srcMask,   "MOV read");
        addVec(8'h59, 4, mk(0,1,2'b01,2'b00,2'b00,0,3'd0,1,0), writeMask, "MOV write");
        addVec(8'h00, 1, mk(0,0,2'b00,2'b00,2'b00,0,3'd0,1,0), allMask,   "NOP done");
        addVec(8'h00, 2, idleExp,                              allMask,   "NOP idle");
        addVec(8'hF0, 1, mk(0,0,2'b00,2'b00,2'b00,0,3'd0,0,1), allMask,   "ILL flag");
        addVec(8'hF0, 2, idleExp,                              allMask,   "ILL ready");

        // Reset state, held across edges.
        applyStimulus(1'b0, 8'h00);
        RST = 1'b1;
        step();
        step();
        checkOutput("reset state", idleExp, allMask);
        RST = 1'b0;
        step();
        checkOutput("after reset", idleExp, allMask);

        // Table-driven vectors, each from a fresh IDLE.
        foreach (vecs[i]) begin
            waitIdle();
            applyStimulus(1'b1, vecs[i].instr);
            step();
            applyStimulus(1'b0, 8'h00);
            for (int c = 1; c < vecs[i].cycle; c++) step();
            checkOutput(vecs[i].name, vecs[i].exp, vecs[i].mask);
        end

        // Async reset while WRITE is driving opwrite.
        waitIdle();
        applyStimulus(1'b1, 8'h11);
        step();
        applyStimulus(1'b0, 8'h00);
        step();
        step();
        step();
        expOut(8'h11, 4, e, m);
        checkOutput("pre-reset write", e, m);
        #2 RST = 1'b1;
        #1 checkOutput("reset in WRITE", idleExp, allMask);
        step();
        RST = 1'b0;
        step();
        checkOutput("after WRITE reset", idleExp, allMask);

        // Back-to-back ADDs with valid held, reset during second EXEC.
        applyStimulus(1'b1, 8'h11);
        checkOutput("b2b c0 ready", idleExp, allMask);
        for (int k = 1; k <= 4; k++) begin
            step();
            expOut(8'h11, k, e, m);
            checkOutput($sformatf("b2b first c%0d", k), e, m);
        end
        step();
        checkOutput("b2b c5 ready", idleExp, allMask);
        for (int k = 1; k <= 3; k++) begin
            step();
            expOut(8'h11, k, e, m);
            checkOutput($sformatf("b2b second c%0d", k + 5), e, m);
        end
        #2 RST = 1'b1;
        #1 checkOutput("reset in EXEC", idleExp, allMask);
        applyStimulus(1'b0, 8'h00);
        step();
        checkOutput("reset held", idleExp, allMask);
        RST = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            checkOutput($sformatf("post reset quiet %0d", k), idleExp, allMask);
        end

        // Randomized instructions with garbage on the bus while busy.
        for (int i = 0; i < 80; i++) begin
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                applyStimulus(1'b0, 8'($urandom));
                checkOutput($sformatf("rand %0d gap", i), idleExp, allMask);
                step();
            end
            ins = randomInstr();
            applyStimulus(1'b1, ins);
            checkOutput($sformatf("rand %0d ready", i), idleExp, allMask);
            step();
            len = traceLen(ins);
            for (int k = 1; k <= len; k++) begin
                applyStimulus(1'($urandom_range(0, 1)), 8'($urandom));
                expOut(ins, k, e, m);
                checkOutput($sformatf("rand %0d instr %h c%0d", i, ins, k), e, m);
                step();
            end
        end
        applyStimulus(1'b0, 8'h00);
        checkOutput("final idle", idleExp, allMask);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/instr_ctrl.md
INSTR_CTRL -- requirements
Module: instr_ctrl

Interface
REQ-001 The block SHALL have one parameter: MUL_CYCLES, default 4, EXEC-state length for MUL (legal range 1..15).
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port instr_valid, input, 1 bit: an instruction is offered on instr.
REQ-005 The block SHALL have port instr, input, 8 bits, with fields [7:4] opcode, [3:2] src_1 field and [1:0] src_2 field.
REQ-006 The block SHALL have port instr_ready, output, 1 bit: the block can accept an instruction.
REQ-007 The block SHALL have port opwrite, output, 1 bit: register-bank write enable (1 = write, 0 = read).
REQ-008 The block SHALL have ports reg_write, src_1 and src_2, outputs, 2 bits each: register-bank write and read addresses (00 = reg_a, 01 = reg_b, 10 = acc).
REQ-009 The block SHALL have ports alu_en (output, 1 bit) and alu_op (output, 3 bits): ALU enable and operation code.
REQ-010 The block SHALL have ports done and illegal, outputs, 1 bit each: instruction completed, and opcode rejected.

Function
REQ-011 Opcodes SHALL be: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 MOV, 6 MUL; opcodes 7..15 are illegal.
REQ-012 The FSM states SHALL be IDLE, DECODE, READ, EXEC and WRITE; all outputs are Moore decodes of the state, IR and counter.
REQ-013 instr_ready SHALL be 1 only in IDLE; when instr_valid and instr_ready are both 1, instr is captured into IR and the FSM moves to DECODE.
REQ-014 In IDLE with instr_valid = 0, the FSM SHALL stay in IDLE.
REQ-015 DECODE SHALL transition as follows:
- illegal opcode: illegal = 1 for that cycle, next state IDLE, no register-bank access.
- NOP: done = 1 for that cycle, next state IDLE.
- any other opcode: next state READ.
REQ-016 In READ, opwrite SHALL be 0 and src_1 = IR[3:2], src_2 = IR[1:0]; these addresses are held through EXEC.
REQ-017 In EXEC, alu_en SHALL be 1 and alu_op = opcode[2:0]; EXEC lasts 1 cycle, or exactly MUL_CYCLES cycles for MUL, timed by a 4-bit down-counter loaded on entry.
REQ-018 In WRITE, opwrite SHALL be 1 and done = 1 for exactly one cycle, then the FSM returns to IDLE.
REQ-019 The WRITE destination SHALL be 2'b10 (acc) for ADD, SUB, AND, OR and MUL; for MOV it is IR[1:0], with the ALU passing src_1 through.
REQ-020 opwrite SHALL be 1 in no state other than WRITE, and alu_en SHALL be 1 in no state other than EXEC.
REQ-021 In every state other than READ, EXEC and WRITE, reg_write, src_1, src_2 and alu_op SHALL be 0.
REQ-022 Latency from the acceptance edge SHALL be: 4 cycles to done for 1-cycle ops, 3 + MUL_CYCLES cycles for MUL, 1 cycle for NOP and for illegal.
REQ-023 Back-to-back throughput SHALL be: the next instruction is accepted on the cycle after WRITE (or after DECODE for NOP/illegal).
REQ-024 instr_valid and instr changes outside IDLE SHALL be ignored; an offered instruction is held by the source until accepted.

Reset
REQ-025 While RST = 1, the block SHALL hold state IDLE, IR = 0, counter = 0, instr_ready = 1 and all other outputs 0.
REQ-026 RST asserted mid-operation, including during WRITE, SHALL force opwrite to 0 asynchronously, abort the instruction and produce no done.

Structure
REQ-027 Opcode values, state encodings and register addresses SHALL live in shared include ctrl_defs.vh, reused by the ALU and the register bank.
REQ-028 Combinational opcode decode (legality, dest, alu_op, is_mul) SHALL be the sub-module instr_decode; the FSM and counter stay in instr_ctrl.

Verification
REQ-029 The bench SHALL cover ADD: instr = 0x1_0_1 (8'h11) accepted at cycle 0 -> src_1 = 00, src_2 = 01 at cycles 2-3; alu_en at cycle 3, alu_op = 1; opwrite = 1, reg_write = 10, done = 1 at cycle 4.
REQ-030 The bench SHALL cover MUL with MUL_CYCLES = 4: instr = 8'h60 -> alu_en high for cycles 3-6, done at cycle 7, reg_write = 10.
REQ-031 The bench SHALL cover MOV: instr = 8'h59 (src acc, dest reg_b) -> src_1 = 10 in READ, reg_write = 01 and opwrite = 1 in WRITE.
REQ-032 The bench SHALL cover NOP and illegal: 8'h00 -> done at cycle 1 with no opwrite; 8'hF0 -> illegal at cycle 1, no done, instr_ready = 1 at cycle 2.
REQ-033 The bench SHALL cover back-to-back with reset: two ADDs with instr_valid held high are accepted at cycles 0 and 5; RST pulsed during the second EXEC gives no opwrite and no done, and instr_ready = 1 while RST is high.
